// File: rtl/tl_pkg.sv
// tl_pkg: shared encodings and field positions for the transaction-layer flow controller
package tl_pkg;
    localparam int DATA_W = 6;
    localparam int VC_BIT = 5;
    localparam int DEST_BIT = 4;
    localparam int AE_LSB = 0;
    localparam int AF_LSB = 4;
    localparam int NIB_W = 4;
    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_INIT   = 3'd1,
        ST_IDLE   = 3'd2,
        ST_ACTIVE = 3'd3,
        ST_ERROR  = 3'd4
    } state_t;
endpackage

// File: rtl/tl_rr_arb2.sv
// tl_rr_arb2: two-requester round-robin arbiter, pointer holds the last conflict winner
module tl_rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);
    logic ptr;
    always_comb gnt = &req ? (ptr ? 2'b01 : 2'b10) : req;
    always_ff @(posedge clk) begin
        if (reset) ptr <= 1'b1;
        else if (advance && &req) ptr <= gnt[1];
    end
endmodule

// File: rtl/tl_flow_ctrl.sv
// tl_flow_ctrl: layer state machine, threshold latching and main/VC/destination routing strobes
module tl_flow_ctrl
    import tl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic [7:0]        umf_cfg,
    input  logic [7:0]        uvc_cfg,
    input  logic [7:0]        ud_cfg,
    output logic [7:0]        umf_q,
    output logic [7:0]        uvc_q,
    output logic [7:0]        ud_q,
    input  logic              main_empty,
    input  logic              vc0_empty,
    input  logic              vc1_empty,
    input  logic              d0_empty,
    input  logic              d1_empty,
    input  logic              vc0_afull,
    input  logic              vc1_afull,
    input  logic              d0_afull,
    input  logic              d1_afull,
    input  logic [DATA_W-1:0] main_head,
    input  logic [DATA_W-1:0] vc0_head,
    input  logic [DATA_W-1:0] vc1_head,
    input  logic [4:0]        fifo_err,
    output logic              pop_main,
    output logic              push_vc0,
    output logic              push_vc1,
    output logic              pop_vc0,
    output logic              pop_vc1,
    output logic              push_d0,
    output logic              push_d1,
    output logic              idle,
    output logic              active,
    output logic              error,
    output logic [2:0]        state
);
    state_t st, st_nx;
    logic en, err, any_data, v, t0, t1;
    logic [1:0] req_d0, req_d1, gnt_d0, gnt_d1;
    logic unused;
    assign unused = ^{main_head[DEST_BIT:0], vc0_head[VC_BIT], vc0_head[DEST_BIT-1:0],
                      vc1_head[VC_BIT], vc1_head[DEST_BIT-1:0], d0_empty, d1_empty};
    assign err = |fifo_err;
    assign any_data = !main_empty || !vc0_empty || !vc1_empty;
    always_comb begin
        st_nx = st;
        if (st == ST_RESET) st_nx = ST_INIT;
        else if (init) st_nx = ST_INIT;
        else if (st == ST_INIT) st_nx = err ? ST_ERROR : ST_IDLE;
        else if (st == ST_IDLE || st == ST_ACTIVE) st_nx = err ? ST_ERROR : (any_data ? ST_ACTIVE : ST_IDLE);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            st    <= ST_RESET;
            umf_q <= '0;
            uvc_q <= '0;
            ud_q  <= '0;
        end else begin
            st <= st_nx;
            if (st == ST_INIT) begin
                umf_q <= umf_cfg;
                uvc_q <= uvc_cfg;
                ud_q  <= ud_cfg;
            end
        end
    end
    assign state  = st;
    assign idle   = st == ST_IDLE;
    assign active = st == ST_ACTIVE;
    assign error  = st == ST_ERROR;
    // strobes fall combinationally with reset so nothing moves on the reset edge
    assign en = active && !reset;
    assign v  = main_head[VC_BIT];
    assign pop_main = en && !main_empty && !(v ? vc1_afull : vc0_afull);
    assign push_vc0 = pop_main && !v;
    assign push_vc1 = pop_main && v;
    assign t0 = vc0_head[DEST_BIT];
    assign t1 = vc1_head[DEST_BIT];
    assign req_d0 = {en && !vc1_empty && !t1 && !d0_afull, en && !vc0_empty && !t0 && !d0_afull};
    assign req_d1 = {en && !vc1_empty && t1 && !d1_afull, en && !vc0_empty && t0 && !d1_afull};
    tl_rr_arb2 u_arb_d0 (.clk(clk), .reset(reset), .req(req_d0), .advance(en), .gnt(gnt_d0));
    tl_rr_arb2 u_arb_d1 (.clk(clk), .reset(reset), .req(req_d1), .advance(en), .gnt(gnt_d1));
    assign pop_vc0 = gnt_d0[0] || gnt_d1[0];
    assign pop_vc1 = gnt_d0[1] || gnt_d1[1];
    assign push_d0 = |gnt_d0;
    assign push_d1 = |gnt_d1;
endmodule

// File: tb/tb_tl_flow_ctrl.sv
// tb_tl_flow_ctrl: directed vectors with hand-computed expectations for tl_flow_ctrl
module tb_tl_flow_ctrl;
    logic clk = 1'b0;
    logic reset, init;
    logic [7:0] umf_cfg, uvc_cfg, ud_cfg, umf_q, uvc_q, ud_q;
    logic main_empty, vc0_empty, vc1_empty, d0_empty, d1_empty;
    logic vc0_afull, vc1_afull, d0_afull, d1_afull;
    logic [5:0] main_head, vc0_head, vc1_head;
    logic [4:0] fifo_err;
    logic pop_main, push_vc0, push_vc1, pop_vc0, pop_vc1, push_d0, push_d1;
    logic idle, active, error;
    logic [2:0] state;
    int checks = 0;
    int errors = 0;

    tl_flow_ctrl dut (
        .clk(clk), .reset(reset), .init(init),
        .umf_cfg(umf_cfg), .uvc_cfg(uvc_cfg), .ud_cfg(ud_cfg),
        .umf_q(umf_q), .uvc_q(uvc_q), .ud_q(ud_q),
        .main_empty(main_empty), .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
        .d0_empty(d0_empty), .d1_empty(d1_empty),
        .vc0_afull(vc0_afull), .vc1_afull(vc1_afull), .d0_afull(d0_afull), .d1_afull(d1_afull),
        .main_head(main_head), .vc0_head(vc0_head), .vc1_head(vc1_head),
        .fifo_err(fifo_err),
        .pop_main(pop_main), .push_vc0(push_vc0), .push_vc1(push_vc1),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1), .push_d0(push_d0), .push_d1(push_d1),
        .idle(idle), .active(active), .error(error), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] strobes();
        return {pop_main, push_vc0, push_vc1, pop_vc0, pop_vc1, push_d0, push_d1};
    endfunction

    initial begin
        reset = 1; init = 0;
        umf_cfg = 8'h30; uvc_cfg = 8'hE0; ud_cfg = 8'h30;
        main_empty = 1; vc0_empty = 1; vc1_empty = 1; d0_empty = 1; d1_empty = 1;
        vc0_afull = 0; vc1_afull = 0; d0_afull = 0; d1_afull = 0;
        main_head = '0; vc0_head = '0; vc1_head = '0; fifo_err = '0;
        step(); step();
        chk("rst_state", state, 0);
        chk("rst_flags", {idle, active, error}, 0);
        chk("rst_umf_q", umf_q, 0);
        chk("rst_strobes", strobes(), 0);
        reset = 0;
        step();
        chk("to_init", state, 1);
        init = 1;
        step();
        chk("init_hold", state, 1);
        chk("init_umf_q", umf_q, 8'h30);
        init = 0;
        step();
        chk("to_idle", state, 2);
        chk("idle_flag", idle, 1);
        chk("uvc_q", uvc_q, 8'hE0);
        chk("ud_q", ud_q, 8'h30);
        umf_cfg = 8'h55;
        main_empty = 0; main_head = 6'b000000;
        #1 chk("idle_no_strobe", strobes(), 0);
        step();
        chk("to_active", state, 3);
        chk("cfg_ignored", umf_q, 8'h30);
        chk("main_vc0", strobes(), 7'b1100000);
        main_head = 6'b100010;
        #1 chk("main_vc1", strobes(), 7'b1010000);
        vc1_afull = 1;
        #1 chk("vc1_afull_hold", strobes(), 0);
        vc1_afull = 0; main_empty = 1;
        vc0_empty = 0; vc1_empty = 0; vc0_head = 6'b010001; vc1_head = 6'b110011;
        for (int i = 0; i < 4; i++) begin
            #1 chk($sformatf("rr_d1_%0d", i), strobes(), (i % 2 == 0) ? 7'b0001001 : 7'b0000101);
            step();
        end
        vc0_head = 6'b000100; vc1_head = 6'b010101;
        #1 chk("split_dest", strobes(), 7'b0001111);
        step();
        vc0_head = 6'b010001; vc1_head = 6'b110011;
        #1 chk("ptr_d1_kept", strobes(), 7'b0001001);
        vc0_head = 6'b000100; vc1_head = 6'b000101;
        #1 chk("d0_first_conflict", strobes(), 7'b0001010);
        vc1_empty = 1; d0_afull = 1;
        #1 chk("d0_afull_hold", strobes(), 0);
        step();
        chk("d0_afull_hold2", strobes(), 0);
        d0_afull = 0;
        #1 chk("d0_release", strobes(), 7'b0001010);
        fifo_err = 5'b00001;
        #1 chk("err_same_cycle", strobes(), 7'b0001010);
        step();
        chk("to_error", {state, error}, {3'd4, 1'b1});
        chk("err_strobes", strobes(), 0);
        step();
        chk("err_sticky", state, 4);
        init = 1;
        step();
        chk("err_to_init", state, 1);
        init = 0; fifo_err = 0;
        step();
        chk("init_to_idle", state, 2);
        chk("umf_q_reload", umf_q, 8'h55);
        step();
        chk("reactivate", state, 3);
        chk("pre_reset_xfer", strobes(), 7'b0001010);
        reset = 1;
        #1 chk("reset_drops", strobes(), 0);
        step();
        chk("reset_state", state, 0);
        chk("reset_q", {umf_q, uvc_q, ud_q}, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/tl_flow_ctrl.md
# tl_flow_ctrl

Sequencing and arbitration controller for the transaction layer: main FIFO, two virtual-channel FIFOs (VC0/VC1), two destination FIFOs (D0/D1).
- Holds the layer state machine: RESET, INIT, IDLE, ACTIVE, ERROR.
- Latches the threshold configuration (UMF/UVC/UD) and drives it to the FIFOs.
- Generates every internal pop/push: main→VC routing, then VC→destination routing, with round-robin sharing of each destination between VC0 and VC1.
- The external consumer still owns pop_d0/pop_d1.

## Interface
- DATA_W, 6, word width; bit 5 = VC select, bit 4 = destination select
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- init  in  1  (re)configuration request
- umf_cfg, uvc_cfg, ud_cfg  in  8 each  thresholds: [3:0] almost-empty, [7:4] almost-full
- umf_q, uvc_q, ud_q  out  8 each  latched thresholds driven to main, VC and D FIFOs
- main_empty, vc0_empty, vc1_empty, d0_empty, d1_empty  in  1 each  FIFO empty flags
- vc0_afull, vc1_afull, d0_afull, d1_afull  in  1 each  almost-full flags, computed by the FIFOs from *_q
- main_head, vc0_head, vc1_head  in  DATA_W each  first-word-fall-through head, valid when !empty
- fifo_err  in  5  overflow/underflow per FIFO: {d1,d0,vc1,vc0,main}
- pop_main, push_vc0, push_vc1, pop_vc0, pop_vc1, push_d0, push_d1  out  1 each  combinational strobes
- idle, active, error  out  1 each  registered state decode
- state  out  3  RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4

## Operation
- While reset=1 the state machine is forced to RESET.
- RESET→INIT on the first edge with reset=0.
- INIT: *_q load from *_cfg on every edge. Leave when init=0, going to ERROR if any fifo_err bit is set, else to IDLE.
- IDLE→ACTIVE when any of main/vc0/vc1 is non-empty.
- ACTIVE→IDLE when main, vc0 and vc1 are all empty.
- IDLE/ACTIVE→ERROR when |fifo_err. This takes precedence over the IDLE/ACTIVE moves.
- Any non-RESET state→INIT when init=1. init takes precedence over error and also exits ERROR. ERROR is otherwise sticky until reset or init.
- Strobes are asserted only when state==ACTIVE and reset==0. Every strobe drops in the same cycle reset is raised.
- Main→VC stage:
  - v = main_head[5].
  - pop_main = !main_empty & !vcv_afull.
  - push_vcv = pop_main.
- VC→D stage:
  - VCi is eligible when !vci_empty. Its target is d = vci_head[4].
  - The request needs !dd_afull.
  - Targets differ: both are granted.
  - Targets are equal: one grant per destination, round-robin. Each destination keeps a 1-bit last-grant pointer; a conflict goes to the VC not granted last.
  - The pointer updates only on a conflict grant.
  - A grant gives pop_vci=1 and push_dd=1.
- The two stages are independent. A VC may be pushed and popped in the same cycle.

## Timing
- Reset values:
  - state=RESET, idle=active=error=0.
  - umf_q=uvc_q=ud_q=0.
  - Round-robin pointers = VC1, so the first conflict goes to VC0.
  - All strobes 0.
- idle, active and error are decoded from the state register.
- Strobes are combinational from current flags and the state register. They are visible in the same cycle as the flags, with no pipeline latency.
- Data moves on the edge ending the strobe cycle. Throughput is 1 word/cycle main→VC and up to 2 words/cycle VC→D.
- ACTIVE is entered one cycle after data appears. The first transfer happens in the first ACTIVE cycle.
- afull is sampled in the same cycle: with afull=1 the source is held and there is no pop. Since afull ≤ depth, no overflow occurs.
- *_q are stable outside INIT. Changing *_cfg outside INIT has no effect.

## Structure
- Package tl_pkg holds:
  - state encodings
  - VC_BIT=5, DEST_BIT=4
  - threshold nibble field positions
- Sub-module tl_rr_arb2: 2-requester round-robin arbiter with a pointer register. Two instances, one per destination. Inputs are clk, reset, req[1:0], advance. Output is gnt[1:0].

## Test plan
- Reset 2 cycles, umf_cfg=8'h30, uvc_cfg=8'hE0, ud_cfg=8'h30, init pulse for 1 cycle → state RESET→INIT→IDLE; umf_q=8'h30, uvc_q=8'hE0; idle=1.
- Main head 6'b000000, then 6'b100010, VCs not afull → pop_main on both; push_vc0, then push_vc1; state IDLE→ACTIVE one cycle after main non-empty.
- vc0_head=6'b010001, vc1_head=6'b110011 (both D1), held 4 cycles → grants alternate VC0, VC1, VC0, VC1; push_d1 every cycle; push_d0=0.
- vc0_head=6'b000100 (D0), vc1_head=6'b010101 (D1) → pop_vc0, pop_vc1, push_d0, push_d1 all 1 in the same cycle; pointers unchanged.
- d0_afull=1 with VC0 targeting D0 → pop_vc0=0, push_d0=0 until d0_afull=0, then transfer the next cycle.
- fifo_err=5'b00001 in ACTIVE → next cycle error=1 and all strobes 0; stays there; init pulse → INIT, then IDLE once fifo_err=0; reset mid-transfer → strobes 0 in that cycle and state=RESET after the edge.
